// File: rtl/array_frame_loader.sv
// array_frame_loader: collects a DEPTH-word frame from a valid/ready stream into a register array,
// then replays it in index order. Define ARRAY_FRAME_LOADER_SUM_EN to add the frame-sum output.
module array_frame_loader #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out1,
  input  logic             out_ready,
  output logic             frame_done
`ifdef ARRAY_FRAME_LOADER_SUM_EN
  ,
  output logic [WIDTH-1:0] sum
`endif
);

  localparam int unsigned     IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("array_frame_loader: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    StInitial = 2'd0,
    StFill    = 2'd1,
    StDrain   = 2'd2,
    StIllegal = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]  rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]  rd_next;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             wr_en;

  // Frame storage; deliberately not reset, a drain only ever follows a complete refill.
  logic [WIDTH-1:0] arr [DEPTH-1:0];

  assign rd_next   = rd_idx_q + IdxW'(1);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out1      = out1_q;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out1_d      = out1_q;
    wr_en       = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      StInitial: begin
        state_d     = StFill;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out1_d      = '0;
        wr_idx_d    = '0;
        rd_idx_d    = '0;
      end

      StFill: begin
        out_valid_d = 1'b0;
        out1_d      = '0;
        if (in_valid && in_ready_q) begin
          wr_en = 1'b1;
          if (wr_idx_q == LastIdx) begin
            // arr[0] was written on an earlier edge, so the first word can be loaded now.
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            state_d     = StDrain;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out1_d      = arr[0];
          end else begin
            wr_idx_d = wr_idx_q + IdxW'(1);
          end
        end
      end

      StDrain: begin
        in_ready_d = 1'b0;
        if (out_valid_q && out_ready) begin
          if (rd_idx_q == LastIdx) begin
            frame_done  = 1'b1;
            state_d     = StFill;
            out_valid_d = 1'b0;
            out1_d      = '0;
            in_ready_d  = 1'b1;
            rd_idx_d    = '0;
          end else begin
            rd_idx_d = rd_next;
            out1_d   = arr[rd_next];
          end
        end
      end

      default: begin
        state_d     = StInitial;
        wr_idx_d    = '0;
        rd_idx_d    = '0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out1_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StInitial;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out1_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      arr[wr_idx_q] <= in1;
    end
  end

`ifdef ARRAY_FRAME_LOADER_SUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;

  // Cleared on every entry to FILL, so it holds the finished frame total through DRAIN.
  always_comb begin
    sum_d = sum_q;
    case (state_q)
      StFill: begin
        if (wr_en) begin
          sum_d = sum_q + in1;
        end
      end
      StDrain: begin
        if (frame_done) begin
          sum_d = '0;
        end
      end
      default: sum_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_array_frame_loader.sv
// Self-checking bench for array_frame_loader: randomized traffic against a queue-based frame model.
// Exercises the sum output too when ARRAY_FRAME_LOADER_SUM_EN is defined.
module tb_array_frame_loader;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in1 = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out1;
  logic             frame_done;
`ifdef ARRAY_FRAME_LOADER_SUM_EN
  logic [WIDTH-1:0] sum;
`endif

  array_frame_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in1       (in1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out1      (out1),
    .out_ready (out_ready),
    .frame_done(frame_done)
`ifdef ARRAY_FRAME_LOADER_SUM_EN
    ,
    .sum       (sum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame model: 0 = waiting one cycle after reset, 1 = collecting, 2 = replaying.
  int               phase = 0;
  int               frames_model = 0;
  logic [WIDTH-1:0] fill_buf[$];
  logic [WIDTH-1:0] drain_buf[$];
  logic [WIDTH-1:0] fill_total = '0;
  logic [WIDTH-1:0] frame_total = '0;

  logic             obs_in_ready, obs_out_valid, obs_frame_done;
  logic [WIDTH-1:0] obs_out1, obs_sum;
  logic             exp_in_ready, exp_out_valid, exp_frame_done;
  logic [WIDTH-1:0] exp_out1, exp_sum;

  task automatic model_reset();
    phase = 0;
    fill_buf.delete();
    drain_buf.delete();
    fill_total  = '0;
    frame_total = '0;
  endtask

  // Drive one cycle, sample on the falling edge, derive expectations, then advance the model.
  task automatic run_cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in1       = d;
    out_ready = r;
    @(negedge clk);
    obs_in_ready   = in_ready;
    obs_out_valid  = out_valid;
    obs_out1       = out1;
    obs_frame_done = frame_done;
`ifdef ARRAY_FRAME_LOADER_SUM_EN
    obs_sum = sum;
`else
    obs_sum = '0;
`endif
    exp_in_ready   = (phase == 1);
    exp_out_valid  = (phase == 2);
    exp_out1       = (phase == 2) ? drain_buf[0] : '0;
    exp_frame_done = (phase == 2) && r && (drain_buf.size() == 1);
    exp_sum        = (phase == 1) ? fill_total : ((phase == 2) ? frame_total : '0);
    if (phase == 0) begin
      phase = 1;
    end else if (phase == 1) begin
      if (v) begin
        fill_buf.push_back(d);
        fill_total = fill_total + d;
        if (fill_buf.size() == DEPTH) begin
          drain_buf   = fill_buf;
          frame_total = fill_total;
          fill_buf.delete();
          fill_total = '0;
          phase      = 2;
        end
      end
    end else if (r) begin
      void'(drain_buf.pop_front());
      if (drain_buf.size() == 0) begin
        phase = 1;
        frames_model++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out1 !== '0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold got rdy=%b vld=%b out1=%h done=%b want all 0",
                 in_ready, out_valid, out1, frame_done);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, '0, 1'b0);
      total++;
      if (obs_in_ready !== exp_in_ready) begin
        bad++;
        $display("FAIL reset_in_ready cyc%0d got %b want %b", i, obs_in_ready, exp_in_ready);
      end
      total++;
      if (obs_out_valid !== 1'b0 || obs_out1 !== '0) begin
        bad++;
        $display("FAIL reset_out cyc%0d got vld=%b out1=%h want 0/0", i, obs_out_valid, obs_out1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got[$];
    int done_cnt = 0;
    int done_at  = -1;
    for (int i = 0; i < DEPTH; i++) begin
      run_cycle(1'b1, WIDTH'(i + 1), 1'b1);
      total++;
      if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid) begin
        bad++;
        $display("FAIL b2b_fill cyc%0d got rdy=%b vld=%b want rdy=%b vld=%b", i,
                 obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid);
      end
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      run_cycle(1'b0, '0, 1'b1);
      total++;
      if (obs_out_valid !== exp_out_valid || obs_out1 !== exp_out1) begin
        bad++;
        $display("FAIL b2b_out cyc%0d got vld=%b out1=%h want vld=%b out1=%h", c,
                 obs_out_valid, obs_out1, exp_out_valid, exp_out1);
      end
      total++;
      if (obs_frame_done !== exp_frame_done || obs_in_ready !== exp_in_ready) begin
        bad++;
        $display("FAIL b2b_ctl cyc%0d got done=%b rdy=%b want done=%b rdy=%b", c,
                 obs_frame_done, obs_in_ready, exp_frame_done, exp_in_ready);
      end
      if (obs_out_valid === 1'b1) got.push_back(obs_out1);
      if (obs_frame_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (i >= got.size() || got[i] !== WIDTH'(i + 1)) begin
        bad++;
        $display("FAIL b2b_seq word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 'x, WIDTH'(i + 1));
      end
    end
    total++;
    if (done_cnt != 1 || done_at != DEPTH - 1) begin
      bad++;
      $display("FAIL b2b_done got count=%0d at=%0d want 1 at %0d", done_cnt, done_at, DEPTH - 1);
    end
  endtask

  task automatic test_backpressure();
    int  idx   = 0;
    int  stall = 0;
    int  cyc   = 0;
    logic r;
    for (int i = 0; i < DEPTH; i++) run_cycle(1'b1, WIDTH'(32'hA0 + i), 1'b1);
    while (phase == 2 && cyc < 40) begin
      r = !(idx == 2 && stall < 3);
      run_cycle(1'b0, '0, r);
      cyc++;
      total++;
      if (obs_out_valid !== exp_out_valid || obs_out1 !== exp_out1 ||
          obs_frame_done !== exp_frame_done) begin
        bad++;
        $display("FAIL bp_out cyc%0d got vld=%b out1=%h done=%b want vld=%b out1=%h done=%b",
                 cyc, obs_out_valid, obs_out1, obs_frame_done, exp_out_valid, exp_out1,
                 exp_frame_done);
      end
      if (!r) begin
        total++;
        if (obs_out_valid !== 1'b1 || obs_out1 !== 32'hA2) begin
          bad++;
          $display("FAIL bp_hold stall%0d got vld=%b out1=%h want 1/a2", stall,
                   obs_out_valid, obs_out1);
        end
        stall++;
      end else if (exp_out_valid) begin
        total++;
        if (obs_out1 !== WIDTH'(32'hA0 + idx)) begin
          bad++;
          $display("FAIL bp_word idx%0d got %h want %h", idx, obs_out1, WIDTH'(32'hA0 + idx));
        end
        idx++;
      end
    end
    total++;
    if (phase == 2 || idx != DEPTH || stall != 3) begin
      bad++;
      $display("FAIL bp_complete got words=%0d stalls=%0d want %0d/3", idx, stall, DEPTH);
    end
  endtask

  task automatic test_bubbles_ignored();
    int cyc = 0;
    logic [WIDTH-1:0] d;
    while (phase != 2 && cyc < 64) begin
      d = 32'h8000_0000 | $urandom;
      run_cycle((cyc % 2) == 0, d, 1'b1);
      cyc++;
      total++;
      if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid) begin
        bad++;
        $display("FAIL bub_fill cyc%0d got rdy=%b vld=%b want rdy=%b vld=%b", cyc,
                 obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid);
      end
    end
    cyc = 0;
    while (phase == 2 && cyc < 64) begin
      run_cycle(1'b1, 32'h0000_DEAD, ($urandom_range(0, 1) != 0));
      cyc++;
      total++;
      if (obs_out_valid !== exp_out_valid || obs_out1 !== exp_out1 ||
          obs_in_ready !== exp_in_ready || obs_frame_done !== exp_frame_done) begin
        bad++;
        $display("FAIL bub_drain cyc%0d got vld=%b out1=%h rdy=%b done=%b want %b/%h/%b/%b",
                 cyc, obs_out_valid, obs_out1, obs_in_ready, obs_frame_done,
                 exp_out_valid, exp_out1, exp_in_ready, exp_frame_done);
      end
      total++;
      if (obs_out_valid === 1'b1 && obs_out1 === 32'h0000_DEAD) begin
        bad++;
        $display("FAIL bub_dead got out1=%h want any word but 0000dead", obs_out1);
      end
    end
    total++;
    if (phase != 1) begin
      bad++;
      $display("FAIL bub_timeout got phase=%0d want 1 after frame", phase);
    end
  endtask

  task automatic test_mid_reset();
    logic [WIDTH-1:0] got[$];
    int   nxt = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   start;
    logic v, r;
    for (int i = 0; i < 5; i++) run_cycle(1'b1, WIDTH'(32'h50 + i), 1'b1);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out1 !== '0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async got rdy=%b vld=%b out1=%h done=%b want all 0",
               in_ready, out_valid, out1, frame_done);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    start = frames_model;
    while (frames_model == start && cyc < 200) begin
      v = (nxt < DEPTH) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      run_cycle(v, v ? WIDTH'(32'h10 + nxt) : WIDTH'($urandom), r);
      if (v && exp_in_ready) nxt++;
      cyc++;
      total++;
      if (obs_out_valid !== exp_out_valid || obs_out1 !== exp_out1 ||
          obs_in_ready !== exp_in_ready) begin
        bad++;
        $display("FAIL mid_cycle cyc%0d got vld=%b out1=%h rdy=%b want %b/%h/%b", cyc,
                 obs_out_valid, obs_out1, obs_in_ready, exp_out_valid, exp_out1, exp_in_ready);
      end
      if (obs_out_valid === 1'b1 && r) got.push_back(obs_out1);
      if (obs_frame_done === 1'b1) done_cnt++;
    end
    total++;
    if (got.size() != DEPTH || done_cnt != 1) begin
      bad++;
      $display("FAIL mid_count got words=%0d done=%0d want %0d/1", got.size(), done_cnt, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (i >= got.size() || got[i] !== WIDTH'(32'h10 + i)) begin
        bad++;
        $display("FAIL mid_word%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 'x, WIDTH'(32'h10 + i));
      end
    end
  endtask

  task automatic test_random();
    int start = frames_model;
    int cyc   = 0;
    while (frames_model < start + 3 && cyc < 600) begin
      run_cycle(($urandom_range(0, 1) != 0), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
      cyc++;
      total++;
      if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid ||
          obs_out1 !== exp_out1 || obs_frame_done !== exp_frame_done) begin
        bad++;
        $display("FAIL rnd cyc%0d got rdy=%b vld=%b out1=%h done=%b want %b/%b/%h/%b", cyc,
                 obs_in_ready, obs_out_valid, obs_out1, obs_frame_done,
                 exp_in_ready, exp_out_valid, exp_out1, exp_frame_done);
      end
`ifdef ARRAY_FRAME_LOADER_SUM_EN
      total++;
      if (obs_sum !== exp_sum) begin
        bad++;
        $display("FAIL rnd_sum cyc%0d got %h want %h", cyc, obs_sum, exp_sum);
      end
`endif
    end
    total++;
    if (frames_model < start + 3) begin
      bad++;
      $display("FAIL rnd_timeout got frames=%0d want %0d", frames_model - start, 3);
    end
  endtask

`ifdef ARRAY_FRAME_LOADER_SUM_EN
  task automatic test_sum();
    logic [WIDTH-1:0] want;
    int cyc;
    for (int f = 0; f < 2; f++) begin
      want = (f == 0) ? 32'hFFFF_FFF8 : 32'd36;
      for (int i = 0; i < DEPTH; i++) begin
        run_cycle(1'b1, (f == 0) ? 32'hFFFF_FFFF : WIDTH'(i + 1), 1'b1);
        total++;
        if (obs_sum !== exp_sum) begin
          bad++;
          $display("FAIL sum_fill f%0d i%0d got %h want %h", f, i, obs_sum, exp_sum);
        end
      end
      cyc = 0;
      while (phase == 2 && cyc < 64) begin
        run_cycle(1'b0, '0, ($urandom_range(0, 2) != 0));
        cyc++;
        total++;
        if (obs_sum !== want || obs_out_valid !== 1'b1) begin
          bad++;
          $display("FAIL sum_drain f%0d cyc%0d got sum=%h vld=%b want %h/1", f, cyc,
                   obs_sum, obs_out_valid, want);
        end
      end
    end
    run_cycle(1'b0, '0, 1'b1);
    total++;
    if (obs_sum !== '0) begin
      bad++;
      $display("FAIL sum_clear got %h want 0", obs_sum);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got no finish want finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_bubbles_ignored();
    test_mid_reset();
    test_random();
`ifdef ARRAY_FRAME_LOADER_SUM_EN
    test_sum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
